predicate_hazard_issue_controller: RTL

- Issue sequencer between the trigger-resolution stage and the downstream execute/writeback stages of a TIA processing element.
- Tracks destination types of in-flight instructions in a shadow pipeline and withholds issue grant while any in-flight instruction writes a predicate.
- Supports pipeline stalls, flush and a drain handshake for reconfiguration/halt.

---
 rtl/predicate_hazard_issue_controller_pkg.sv | 29 ++
 rtl/predicate_hazard_issue_controller_shadow_pipeline.sv | 37 +++
 rtl/predicate_hazard_issue_controller.sv | 117 +++++++++++
 3 files changed

// File: rtl/predicate_hazard_issue_controller_pkg.sv
// Shared control types for the predicate hazard issue controller: TIA destination
// types, issue FSM states and the shadow-pipeline entry layout.
package predicate_hazard_issue_controller_pkg;

    localparam int TIA_DT_WIDTH = 2;

    localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_NULL      = 2'd0;
    localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_REGISTER  = 2'd1;
    localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_OUTPUT    = 2'd2;
    localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_PREDICATE = 2'd3;

    typedef enum logic [1:0] {
        STATE_RUN      = 2'd0,
        STATE_DRAINING = 2'd1,
        STATE_DRAINED  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic                    valid;
        logic [TIA_DT_WIDTH-1:0] dt;
    } shadow_entry_t;

    localparam int SHADOW_ENTRY_WIDTH = $bits(shadow_entry_t);

    function automatic logic is_predicate_write(input shadow_entry_t entry);
        return entry.valid && (entry.dt == TIA_DESTINATION_TYPE_PREDICATE);
    endfunction

endpackage

// File: rtl/predicate_hazard_issue_controller_shadow_pipeline.sv
// Shadow of the downstream execute/writeback stages: one {valid, dt} entry per stage,
// shifted in lockstep with the real pipeline so issue can see in-flight predicate writes.
module control_hazard_shadow_pipeline
    import predicate_hazard_issue_controller_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   advance,
    input  logic                                   flush,
    input  logic                                   insert,
    input  logic [TIA_DT_WIDTH-1:0]                insert_dt,
    output logic [NUM_STAGES*SHADOW_ENTRY_WIDTH-1:0] entries
);

    shadow_entry_t stage_q [NUM_STAGES];

    // Flush wins over advance so squashed work never reappears one stage further on.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            stage_q[0] <= insert ? shadow_entry_t'{valid: 1'b1, dt: insert_dt} : '0;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_flatten
        assign entries[g*SHADOW_ENTRY_WIDTH +: SHADOW_ENTRY_WIDTH] = stage_q[g];
    end

endmodule

// File: rtl/predicate_hazard_issue_controller.sv
// Issue sequencer for a TIA processing element: withholds grant while a predicate write
// is in flight, and supports stall, flush and a drain handshake for reconfiguration.
module predicate_hazard_issue_controller
    import predicate_hazard_issue_controller_pkg::*;
#(
    parameter int NUM_DOWNSTREAM_STAGES = 2,
    parameter int STALL_COUNTER_WIDTH   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           issue_valid,
    input  logic [TIA_DT_WIDTH-1:0]        issue_dt,
    input  logic                           downstream_stall,
    input  logic                           flush,
    input  logic                           drain_request,
    output logic                           issue_grant,
    output logic                           hazard,
    output logic                           drained,
    output logic [2:0]                     in_flight_predicate_count,
    output logic [STALL_COUNTER_WIDTH-1:0] stall_cycle_count
);

    issue_state_t state_q;
    issue_state_t state_d;

    logic advance;
    logic flush_active;
    logic any_valid;
    logic [NUM_DOWNSTREAM_STAGES*SHADOW_ENTRY_WIDTH-1:0] entries;
    shadow_entry_t entry [NUM_DOWNSTREAM_STAGES];

    assign advance      = enable && !downstream_stall;
    assign flush_active = enable && flush;

    control_hazard_shadow_pipeline #(
        .NUM_STAGES (NUM_DOWNSTREAM_STAGES)
    ) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .advance   (advance),
        .flush     (flush_active),
        .insert    (issue_grant),
        .insert_dt (issue_dt),
        .entries   (entries)
    );

    for (genvar g = 0; g < NUM_DOWNSTREAM_STAGES; g++) begin : g_unpack
        assign entry[g] = shadow_entry_t'(entries[g*SHADOW_ENTRY_WIDTH +: SHADOW_ENTRY_WIDTH]);
    end

    always_comb begin
        hazard                    = 1'b0;
        any_valid                 = 1'b0;
        in_flight_predicate_count = '0;
        for (int i = 0; i < NUM_DOWNSTREAM_STAGES; i++) begin
            if (is_predicate_write(entry[i])) begin
                hazard                    = 1'b1;
                in_flight_predicate_count = in_flight_predicate_count + 3'd1;
            end
            if (entry[i].valid) begin
                any_valid = 1'b1;
            end
        end
    end

    // Reset is synchronous, so gate grant during it to keep the reset cycle issue-free.
    assign issue_grant = !reset && issue_valid && advance && !hazard && !flush
                         && (state_q == STATE_RUN);

    assign drained = (state_q == STATE_DRAINED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= STATE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain completion looks at the registered entries, so it lands the cycle after they empty.
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                STATE_RUN: begin
                    if (drain_request) begin
                        state_d = STATE_DRAINING;
                    end
                end
                STATE_DRAINING: begin
                    if (!drain_request) begin
                        state_d = STATE_RUN;
                    end else if (!any_valid) begin
                        state_d = STATE_DRAINED;
                    end
                end
                STATE_DRAINED: begin
                    if (!drain_request) begin
                        state_d = STATE_RUN;
                    end
                end
                default: state_d = STATE_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycle_count <= '0;
        end else if (enable && issue_valid && hazard && (state_q == STATE_RUN)
                     && (stall_cycle_count != '1)) begin
            stall_cycle_count <= stall_cycle_count + STALL_COUNTER_WIDTH'(1);
        end
    end

endmodule
